// File: rtl/fp_mul_ieee.sv
// Four-stage pipelined IEEE-style floating-point multiplier with run-time rounding,
// FTZ subnormal handling and overflow/underflow/invalid flags; one op per cycle.
module fp_mul_ieee #(
   parameter int DATA_W = 32,
   parameter int EXP_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic [1:0]        rnd_mode,
   output logic              done,
   output logic [DATA_W-1:0] res,
   output logic              overflow,
   output logic              underflow,
   output logic              exception
);

   localparam int MAN_W  = DATA_W - EXP_W;
   localparam int FRAC_W = MAN_W - 1;
   localparam int EW     = EXP_W + 2;
   localparam int PROD_W = 2 * MAN_W;

   localparam logic signed [EW-1:0] EXP_ZERO = '0;
   localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
   localparam logic signed [EW-1:0] EXP_BIAS = EW'(2**(EXP_W-1) - 1);
   localparam logic signed [EW-1:0] EXP_OVF  = EW'(2**EXP_W - 1);

   typedef enum logic [1:0] {
      RNE = 2'd0,
      RTZ = 2'd1,
      RDN = 2'd2,
      RUP = 2'd3
   } rnd_t;

   // ---------------- S1: operand capture ----------------
   logic              s1_valid;
   logic [DATA_W-1:0] s1_a;
   logic [DATA_W-1:0] s1_b;
   rnd_t              s1_rnd;

   logic [EXP_W-1:0]  a_exp, b_exp;
   logic [FRAC_W-1:0] a_frac, b_frac;
   logic              a_nan, a_inf, a_zero;
   logic              b_nan, b_inf, b_zero;

   always_comb begin
      a_exp  = s1_a[DATA_W-2 -: EXP_W];
      b_exp  = s1_b[DATA_W-2 -: EXP_W];
      a_frac = s1_a[FRAC_W-1:0];
      b_frac = s1_b[FRAC_W-1:0];
      a_nan  = (&a_exp) & (|a_frac);
      a_inf  = (&a_exp) & ~(|a_frac);
      a_zero = (a_exp == '0);
      b_nan  = (&b_exp) & (|b_frac);
      b_inf  = (&b_exp) & ~(|b_frac);
      b_zero = (b_exp == '0);
   end

   // ---------------- S2: sign, exponent, product ----------------
   logic                     s2_valid;
   rnd_t                     s2_rnd;
   logic                     s2_sign;
   logic signed [EW-1:0]     s2_exp;
   logic [PROD_W-1:0]        s2_prod;
   logic                     s2_inv, s2_inf, s2_zero;

   // ---------------- S3: normalised mantissa + guard/sticky ----------------
   logic                     s3_valid;
   rnd_t                     s3_rnd;
   logic                     s3_sign;
   logic signed [EW-1:0]     s3_exp;
   logic [FRAC_W-1:0]        s3_frac;
   logic                     s3_g, s3_s;
   logic                     s3_inv, s3_inf, s3_zero;

   logic signed [EW-1:0]     norm_exp;
   logic [FRAC_W-1:0]        norm_frac;
   logic                     norm_g, norm_s;

   // Hidden bit is always 1 after normalisation, so only the fraction travels on.
   always_comb begin
      if (s2_prod[PROD_W-1]) begin
         norm_frac = s2_prod[PROD_W-2 -: FRAC_W];
         norm_g    = s2_prod[PROD_W-1-MAN_W];
         norm_s    = |s2_prod[PROD_W-2-MAN_W:0];
         norm_exp  = s2_exp + EXP_ONE;
      end else begin
         norm_frac = s2_prod[PROD_W-3 -: FRAC_W];
         norm_g    = s2_prod[PROD_W-2-MAN_W];
         norm_s    = |s2_prod[PROD_W-3-MAN_W:0];
         norm_exp  = s2_exp;
      end
   end

   // ---------------- S4: rounding, range checks, special override ----------------
   logic                 inc, to_inf;
   logic [FRAC_W:0]      rnd_sum;
   logic [FRAC_W-1:0]    rnd_frac;
   logic signed [EW-1:0] rnd_exp;
   logic [DATA_W-1:0]    res_n;
   logic                 ovf_n, uf_n, exc_n;

   always_comb begin
      inc    = 1'b0;
      to_inf = 1'b0;
      case (s3_rnd)
         RNE: begin inc = s3_g & (s3_frac[0] | s3_s); to_inf = 1'b1;     end
         RTZ: begin inc = 1'b0;                       to_inf = 1'b0;     end
         RDN: begin inc = s3_sign & (s3_g | s3_s);    to_inf = s3_sign;  end
         RUP: begin inc = ~s3_sign & (s3_g | s3_s);   to_inf = ~s3_sign; end
         default: begin inc = 1'b0; to_inf = 1'b0; end
      endcase

      // Carry out of the fraction means the mantissa rolled over to 1.0.
      rnd_sum  = {1'b0, s3_frac} + (FRAC_W+1)'(inc);
      rnd_frac = rnd_sum[FRAC_W-1:0];
      rnd_exp  = rnd_sum[FRAC_W] ? (s3_exp + EXP_ONE) : s3_exp;

      res_n = {s3_sign, rnd_exp[EXP_W-1:0], rnd_frac};
      ovf_n = 1'b0;
      uf_n  = 1'b0;
      exc_n = 1'b0;

      if (s3_inv) begin
         res_n = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
         exc_n = 1'b1;
      end else if (s3_inf) begin
         res_n = {s3_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      end else if (s3_zero) begin
         res_n = {s3_sign, {(DATA_W-1){1'b0}}};
      end else if (s3_exp <= EXP_ZERO) begin
         res_n = {s3_sign, {(DATA_W-1){1'b0}}};
         uf_n  = 1'b1;
      end else if (rnd_exp >= EXP_OVF) begin
         ovf_n = 1'b1;
         if (to_inf)
            res_n = {s3_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
         else
            res_n = {s3_sign, {{(EXP_W-1){1'b1}}, 1'b0}, {FRAC_W{1'b1}}};
      end
   end

   // ---------------- valid chain and output registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         s3_valid  <= 1'b0;
         done      <= 1'b0;
         res       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         exception <= 1'b0;
      end else begin
         s1_valid <= start;
         s2_valid <= s1_valid;
         s3_valid <= s2_valid;
         done     <= s3_valid;
         if (s3_valid) begin
            res       <= res_n;
            overflow  <= ovf_n;
            underflow <= uf_n;
            exception <= exc_n;
         end
      end
   end

   // ---------------- datapath registers (qualified by the valid chain) ----------------
   always_ff @(posedge clk) begin
      s1_a   <= op_a;
      s1_b   <= op_b;
      s1_rnd <= rnd_t'(rnd_mode);

      s2_rnd  <= s1_rnd;
      s2_sign <= s1_a[DATA_W-1] ^ s1_b[DATA_W-1];
      s2_exp  <= $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - EXP_BIAS;
      s2_prod <= PROD_W'({1'b1, a_frac}) * PROD_W'({1'b1, b_frac});
      s2_inv  <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
      s2_inf  <= a_inf | b_inf;
      s2_zero <= a_zero | b_zero;

      s3_rnd  <= s2_rnd;
      s3_sign <= s2_sign;
      s3_exp  <= norm_exp;
      s3_frac <= norm_frac;
      s3_g    <= norm_g;
      s3_s    <= norm_s;
      s3_inv  <= s2_inv;
      s3_inf  <= s2_inf;
      s3_zero <= s2_zero;
   end

endmodule

// File: tb/tb_fp_mul_ieee.sv
// Directed self-checking bench for fp_mul_ieee: latency, ordering, rounding,
// overflow/underflow, special operands and reset behaviour.
module tb_fp_mul_ieee;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [1:0]  rnd_mode;
   logic        done;
   logic [31:0] res;
   logic        overflow;
   logic        underflow;
   logic        exception;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fp_mul_ieee #(.DATA_W(32), .EXP_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op_a      (op_a),
      .op_b      (op_b),
      .rnd_mode  (rnd_mode),
      .done      (done),
      .res       (res),
      .overflow  (overflow),
      .underflow (underflow),
      .exception (exception)
   );

   // Issue one op and wait (bounded) for its done pulse; lat counts negedges after issue.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                         output logic [31:0] r, output logic [2:0] f, output int lat);
      @(negedge clk);
      start = 1'b1; op_a = a; op_b = b; rnd_mode = m;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      r = res;
      f = {overflow, underflow, exception};
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; rnd_mode = 2'd0;
      repeat (3) @(negedge clk);
      checks++;
      if ({done, overflow, underflow, exception} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 0000", {done, overflow, underflow, exception});
      end
      checks++;
      if (res !== 32'h0) begin
         errors++;
         $display("FAIL reset_res: got %h expected 00000000", res);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [31:0] r; logic [2:0] f; int lat;
      run_op(32'h40400000, 32'h40200000, 2'd0, r, f, lat);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", lat); end
      checks++;
      if (r !== 32'h40F00000) begin errors++; $display("FAIL basic_res: got %h expected 40f00000", r); end
      checks++;
      if (f !== 3'b000) begin errors++; $display("FAIL basic_flags: got %b expected 000", f); end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL basic_pulse: done got %b expected 0", done); end
      checks++;
      if (res !== 32'h40F00000) begin errors++; $display("FAIL basic_hold: got %h expected 40f00000", res); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a[4], b[4], e[4], got[4];
      int at[4];
      int n = 0;
      a[0] = 32'h3F800000; b[0] = 32'h3F800000; e[0] = 32'h3F800000;
      a[1] = 32'h40000000; b[1] = 32'h40400000; e[1] = 32'h40C00000;
      a[2] = 32'h3FC00000; b[2] = 32'h3FC00000; e[2] = 32'h40100000;
      a[3] = 32'hC0800000; b[3] = 32'h3E800000; e[3] = 32'hBF800000;
      for (int i = 0; i < 4; i++) begin got[i] = '0; at[i] = -1; end
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (done) begin
            if (n < 4) begin got[n] = res; at[n] = k; end
            n++;
         end
         if (k < 4) begin
            start = 1'b1; op_a = a[k]; op_b = b[k]; rnd_mode = 2'd0;
         end else begin
            start = 1'b0;
         end
      end
      checks++;
      if (n !== 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", n); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (at[i] !== 4 + i) begin errors++; $display("FAIL b2b_slot%0d: got %0d expected %0d", i, at[i], 4 + i); end
         checks++;
         if (got[i] !== e[i]) begin errors++; $display("FAIL b2b_res%0d: got %h expected %h", i, got[i], e[i]); end
      end
   endtask

   task automatic test_overflow();
      logic [31:0] a[3], e[3];
      logic [1:0]  m[3];
      logic [31:0] r; logic [2:0] f; int lat;
      a[0] = 32'h7F000000; m[0] = 2'd0; e[0] = 32'h7F800000;
      a[1] = 32'h7F000000; m[1] = 2'd1; e[1] = 32'h7F7FFFFF;
      a[2] = 32'hFF000000; m[2] = 2'd3; e[2] = 32'hFF7FFFFF;
      for (int i = 0; i < 3; i++) begin
         run_op(a[i], 32'h40000000, m[i], r, f, lat);
         checks++;
         if (r !== e[i]) begin errors++; $display("FAIL ovf_res%0d: got %h expected %h", i, r, e[i]); end
         checks++;
         if (f !== 3'b100) begin errors++; $display("FAIL ovf_flags%0d: got %b expected 100", i, f); end
      end
   endtask

   task automatic test_underflow();
      logic [31:0] a[2], e[2];
      logic [31:0] r; logic [2:0] f; int lat;
      a[0] = 32'h00800000; e[0] = 32'h00000000;
      a[1] = 32'h80800000; e[1] = 32'h80000000;
      for (int i = 0; i < 2; i++) begin
         run_op(a[i], 32'h3F000000, 2'd0, r, f, lat);
         checks++;
         if (r !== e[i]) begin errors++; $display("FAIL uf_res%0d: got %h expected %h", i, r, e[i]); end
         checks++;
         if (f !== 3'b010) begin errors++; $display("FAIL uf_flags%0d: got %b expected 010", i, f); end
      end
   endtask

   task automatic test_special();
      logic [31:0] a[6], b[6], e[6];
      logic [2:0]  ef[6];
      logic [31:0] r; logic [2:0] f; int lat;
      a[0] = 32'h7F800000; b[0] = 32'h00000000; e[0] = 32'h7FC00000; ef[0] = 3'b001;
      a[1] = 32'h7FC00001; b[1] = 32'h3F800000; e[1] = 32'h7FC00000; ef[1] = 3'b001;
      a[2] = 32'hFF800000; b[2] = 32'h40000000; e[2] = 32'hFF800000; ef[2] = 3'b000;
      a[3] = 32'h80000000; b[3] = 32'h40000000; e[3] = 32'h80000000; ef[3] = 3'b000;
      a[4] = 32'h00000001; b[4] = 32'hBF800000; e[4] = 32'h80000000; ef[4] = 3'b000;
      a[5] = 32'h40000000; b[5] = 32'hFFC00000; e[5] = 32'h7FC00000; ef[5] = 3'b001;
      for (int i = 0; i < 6; i++) begin
         run_op(a[i], b[i], 2'd0, r, f, lat);
         checks++;
         if (lat !== 4) begin errors++; $display("FAIL spc_latency%0d: got %0d expected 4", i, lat); end
         checks++;
         if (r !== e[i]) begin errors++; $display("FAIL spc_res%0d: got %h expected %h", i, r, e[i]); end
         checks++;
         if (f !== ef[i]) begin errors++; $display("FAIL spc_flags%0d: got %b expected %b", i, f, ef[i]); end
      end
   endtask

   task automatic test_rounding();
      logic [31:0] a[9], b[9], e[9];
      logic [1:0]  m[9];
      logic [31:0] r; logic [2:0] f; int lat;
      // (1+2^-23)^2: G=0, S=1
      a[0] = 32'h3F800001; b[0] = 32'h3F800001; m[0] = 2'd0; e[0] = 32'h3F800002;
      a[1] = 32'h3F800001; b[1] = 32'h3F800001; m[1] = 2'd1; e[1] = 32'h3F800002;
      a[2] = 32'h3F800001; b[2] = 32'h3F800001; m[2] = 2'd2; e[2] = 32'h3F800002;
      a[3] = 32'h3F800001; b[3] = 32'h3F800001; m[3] = 2'd3; e[3] = 32'h3F800003;
      // 1.5*(1+2^-23): exact tie with odd LSB
      a[4] = 32'h3FC00000; b[4] = 32'h3F800001; m[4] = 2'd0; e[4] = 32'h3FC00002;
      a[5] = 32'h3FC00000; b[5] = 32'h3F800001; m[5] = 2'd1; e[5] = 32'h3FC00001;
      a[6] = 32'h3FC00000; b[6] = 32'h3F800001; m[6] = 2'd2; e[6] = 32'h3FC00001;
      a[7] = 32'hBFC00000; b[7] = 32'h3F800001; m[7] = 2'd2; e[7] = 32'hBFC00002;
      a[8] = 32'hBFC00000; b[8] = 32'h3F800001; m[8] = 2'd3; e[8] = 32'hBFC00001;
      for (int i = 0; i < 9; i++) begin
         run_op(a[i], b[i], m[i], r, f, lat);
         checks++;
         if (r !== e[i]) begin errors++; $display("FAIL rnd_res%0d: got %h expected %h", i, r, e[i]); end
         checks++;
         if (f !== 3'b000) begin errors++; $display("FAIL rnd_flags%0d: got %b expected 000", i, f); end
      end
   endtask

   task automatic test_reset_midflight();
      int n = 0;
      @(negedge clk);
      start = 1'b1; op_a = 32'h40400000; op_b = 32'h40400000; rnd_mode = 2'd0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done) n++;
      end
      checks++;
      if (n !== 0) begin errors++; $display("FAIL midrst_done: got %0d pulses expected 0", n); end
      checks++;
      if (res !== 32'h0) begin errors++; $display("FAIL midrst_res: got %h expected 00000000", res); end
      checks++;
      if ({overflow, underflow, exception} !== 3'b000) begin
         errors++;
         $display("FAIL midrst_flags: got %b expected 000", {overflow, underflow, exception});
      end
   endtask

   task automatic test_rst_with_start();
      int n = 0;
      @(negedge clk);
      rst = 1'b1; start = 1'b1; op_a = 32'h40000000; op_b = 32'h40000000; rnd_mode = 2'd0;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done) n++;
      end
      checks++;
      if (n !== 0) begin errors++; $display("FAIL rststart_done: got %0d pulses expected 0", n); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_overflow();
      test_underflow();
      test_special();
      test_rounding();
      test_reset_midflight();
      test_rst_with_start();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
